// File: rtl/uart_cfg_core.sv
// Full-duplex UART with clock-enable baud timing, configurable width/parity/stop,
// and an oversampling receiver with false-start rejection and error reporting.
`timescale 1ns/1ps
module uart_cfg_core #(
  parameter int unsigned CLK_FREQ   = 1000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned DIV       = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned BIT_CLKS  = DIV * OVERSAMPLE;
  localparam int unsigned STOP_CLKS = STOP_BITS * BIT_CLKS;
  localparam int unsigned TXC_W     = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W      = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W     = $clog2(DATA_BITS);
  localparam logic        PAR_EN    = (PARITY_EN != 0);
  localparam logic        PAR_INV   = (PARITY_ODD != 0);

  if (DIV < 1) begin : g_div_chk
    $error("uart_cfg_core: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_cfg_core: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_cfg_core: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("uart_cfg_core: STOP_BITS must be 1 or 2");
  end

  // ---------------- transmitter ----------------
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  logic [2:0]           tx_state_q, tx_state_d;
  logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_bit_end, tx_stop_end;

  assign tx_bit_end  = (tx_cnt_q == TXC_W'(BIT_CLKS - 1));
  assign tx_stop_end = (tx_cnt_q == TXC_W'(STOP_CLKS - 1));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_INV;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
            tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
            tx_d       = PAR_EN ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_stop_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign tx_done  = (tx_state_q == TX_STOP) && tx_stop_end;
  assign tx       = tx_q;

  // ---------------- receiver ----------------
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;
  localparam logic [2:0] RX_WAIT_H = 3'd5;

  logic                 rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 tick;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_os_q, rx_os_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_out_q, rx_perr_out_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 os_half, os_full;

  assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
  assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  assign os_half   = (rx_os_q == OS_W'(OVERSAMPLE / 2 - 1));
  assign os_full   = (rx_os_q == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_os_d       = rx_os_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_par_d      = rx_par_q;
    rx_perr_d     = rx_perr_q;
    rx_data_d     = rx_data_q;
    rx_perr_out_d = rx_perr_out_q;
    rx_ferr_d     = rx_ferr_q;
    rx_valid_d    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_os_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_os_d = rx_os_q + 1'b1;
          // Mid start bit: a line back high means a glitch, not a frame.
          if (os_half) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_par_d   = 1'b0;
            rx_perr_d  = 1'b0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_os_d = rx_os_q + 1'b1;
          if (os_full) begin
            rx_os_d    = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_par_d   = rx_par_q ^ rx_sync_q;
            if (rx_bit_q == BIT_W'(DATA_BITS - 1))
              rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
            else
              rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          rx_os_d = rx_os_q + 1'b1;
          if (os_full) begin
            rx_os_d    = '0;
            rx_perr_d  = rx_sync_q != (rx_par_q ^ PAR_INV);
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_os_d = rx_os_q + 1'b1;
          if (os_full) begin
            rx_os_d       = '0;
            rx_valid_d    = 1'b1;
            rx_data_d     = rx_shift_q;
            rx_perr_out_d = rx_perr_q;
            rx_ferr_d     = !rx_sync_q;
            rx_state_d    = rx_sync_q ? RX_IDLE : RX_WAIT_H;
          end
        end
      end
      RX_WAIT_H: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      div_cnt_q     <= '0;
      rx_state_q    <= RX_IDLE;
      rx_os_q       <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      div_cnt_q     <= div_cnt_d;
      rx_state_q    <= rx_state_d;
      rx_os_q       <= rx_os_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_q      <= rx_par_d;
      rx_perr_q     <= rx_perr_d;
      rx_data_q     <= rx_data_d;
      rx_perr_out_q <= rx_perr_out_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_valid_q    <= rx_valid_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_busy       = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed bench for uart_cfg_core: three configurations (8N1, 8E1, 5O2) at 16 clk/bit.
`timescale 1ns/1ps
module tb_uart_cfg_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // 8N1 instance, rx driven by the bench
  logic       n_tx_valid = 1'b0, n_tx_ready, n_tx, n_tx_done, n_rx_drv = 1'b1;
  logic [7:0] n_tx_data = '0, n_rx_data;
  logic       n_rx_valid, n_rx_perr, n_rx_ferr, n_rx_busy;
  // 8E1 instance, rx either looped from tx or driven
  logic       e_tx_valid = 1'b0, e_tx_ready, e_tx, e_tx_done, e_rx_drv = 1'b1, e_loop = 1'b0, e_rx;
  logic [7:0] e_tx_data = '0, e_rx_data;
  logic       e_rx_valid, e_rx_perr, e_rx_ferr, e_rx_busy;
  // 5-bit, odd parity, 2 stop bits, looped back
  logic       o_tx_valid = 1'b0, o_tx_ready, o_tx, o_tx_done;
  logic [4:0] o_tx_data = '0, o_rx_data;
  logic       o_rx_valid, o_rx_perr, o_rx_ferr, o_rx_busy;

  assign e_rx = e_loop ? e_tx : e_rx_drv;

  uart_cfg_core #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_valid(n_tx_valid), .tx_data(n_tx_data), .tx_ready(n_tx_ready),
    .tx(n_tx), .tx_done(n_tx_done), .rx(n_rx_drv), .rx_data(n_rx_data), .rx_valid(n_rx_valid),
    .rx_parity_err(n_rx_perr), .rx_frame_err(n_rx_ferr), .rx_busy(n_rx_busy));

  uart_cfg_core #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_valid(e_tx_valid), .tx_data(e_tx_data), .tx_ready(e_tx_ready),
    .tx(e_tx), .tx_done(e_tx_done), .rx(e_rx), .rx_data(e_rx_data), .rx_valid(e_rx_valid),
    .rx_parity_err(e_rx_perr), .rx_frame_err(e_rx_ferr), .rx_busy(e_rx_busy));

  uart_cfg_core #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16), .DATA_BITS(5),
                  .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_5o2 (
    .clk(clk), .rst(rst), .tx_valid(o_tx_valid), .tx_data(o_tx_data), .tx_ready(o_tx_ready),
    .tx(o_tx), .tx_done(o_tx_done), .rx(o_tx), .rx_data(o_rx_data), .rx_valid(o_rx_valid),
    .rx_parity_err(o_rx_perr), .rx_frame_err(o_rx_ferr), .rx_busy(o_rx_busy));

  // rx_valid capture: {frame_err, parity_err, data} per pulse
  int         n_vcnt = 0, e_vcnt = 0, o_vcnt = 0;
  logic [9:0] n_cap [0:7];
  logic [9:0] e_cap [0:7];
  logic [9:0] o_cap [0:7];

  always @(posedge clk) begin
    if (n_rx_valid) begin
      n_cap[n_vcnt[2:0]] <= {n_rx_ferr, n_rx_perr, n_rx_data};
      n_vcnt <= n_vcnt + 1;
    end
    if (e_rx_valid) begin
      e_cap[e_vcnt[2:0]] <= {e_rx_ferr, e_rx_perr, e_rx_data};
      e_vcnt <= e_vcnt + 1;
    end
    if (o_rx_valid) begin
      o_cap[o_vcnt[2:0]] <= {o_rx_ferr, o_rx_perr, 3'b000, o_rx_data};
      o_vcnt <= o_vcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an LSB-first bit vector on the selected rx line, 16 clk per bit, starting at a negedge.
  task automatic drive_rx(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) n_rx_drv = bits[i];
      else            e_rx_drv = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  logic [15:0] frame;
  int          match [0:15];
  int          rdy_bad, done_cnt, done_at, base;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(n_tx), 32'd1);
    check("rst_tx_ready", 32'(n_tx_ready), 32'd1);
    check("rst_tx_done", 32'(n_tx_done), 32'd0);
    check("rst_rx_busy", 32'(n_rx_busy), 32'd0);
    check("rst_rx_data", 32'(e_rx_data), 32'd0);

    // ---------------- 8N1 TX 0xA5 ----------------
    frame = {5'b0, 1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 16; b++) match[b] = 0;
    rdy_bad = 0; done_cnt = 0; done_at = -1;
    n_tx_data = 8'hA5; n_tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tx_valid = 1'b0;
    for (int j = 0; j < 160; j++) begin
      if (n_tx === frame[j / 16]) match[j / 16]++;
      if (n_tx_ready !== 1'b0) rdy_bad++;
      if (n_tx_done === 1'b1) begin done_cnt++; done_at = j; end
      if (j == 50) begin n_tx_data = 8'hFF; n_tx_valid = 1'b1; end
      if (j == 53) n_tx_valid = 1'b0;
      @(negedge clk);
    end
    for (int b = 0; b < 10; b++) check($sformatf("a5_bit%0d_clks", b), 32'(match[b]), 32'd16);
    check("a5_ready_low_clks_bad", 32'(rdy_bad), 32'd0);
    check("a5_done_pulses", 32'(done_cnt), 32'd1);
    check("a5_done_latency", 32'(done_at + 1), 32'd160);
    check("a5_ready_after", 32'(n_tx_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("a5_second_valid_ignored_tx", 32'(n_tx), 32'd1);
    check("a5_second_valid_ignored_rdy", 32'(n_tx_ready), 32'd1);

    // ---------------- 8E1 loopback 0x37 then 0xC8 ----------------
    e_loop = 1'b1;
    e_tx_data = 8'h37; e_tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e_tx_data = 8'hC8;
    for (int i = 0; i < 400 && !e_tx_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    e_tx_valid = 1'b0;
    check("e1_second_accepted", 32'(e_tx_ready), 32'd0);
    for (int i = 0; i < 500 && e_vcnt < 2; i++) @(negedge clk);
    check("e1_rx_count", 32'(e_vcnt), 32'd2);
    check("e1_rx_frame0", 32'(e_cap[0]), 32'h037);
    check("e1_rx_frame1", 32'(e_cap[1]), 32'h0C8);
    for (int i = 0; i < 400 && !(e_tx_ready && !e_rx_busy); i++) @(negedge clk);
    check("e1_idle_after", 32'(e_tx_ready && !e_rx_busy), 32'd1);

    // ---------------- 8E1 driven rx, bad parity ----------------
    e_loop = 1'b0;
    drive_rx(1, {5'b0, 1'b1, 1'b0, 8'h37, 1'b0}, 11);
    e_rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("perr_rx_count", 32'(e_vcnt), 32'd3);
    check("perr_rx_frame", 32'(e_cap[2]), 32'h137);

    // ---------------- 8N1 false start and held break ----------------
    n_rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_seen", 32'(n_rx_busy), 32'd1);
    n_rx_drv = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_clear", 32'(n_rx_busy), 32'd0);
    check("glitch_no_valid", 32'(n_vcnt), 32'd0);
    drive_rx(0, {6'b0, 8'h5A, 1'b0}, 10);
    repeat (100) @(negedge clk);
    check("break_rx_count", 32'(n_vcnt), 32'd1);
    check("break_rx_frame", 32'(n_cap[0]), 32'h25A);
    check("break_busy_held", 32'(n_rx_busy), 32'd1);
    n_rx_drv = 1'b1;
    repeat (6) @(negedge clk);
    check("break_busy_release", 32'(n_rx_busy), 32'd0);
    check("break_no_extra_valid", 32'(n_vcnt), 32'd1);
    drive_rx(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (20) @(negedge clk);
    check("after_break_count", 32'(n_vcnt), 32'd2);
    check("after_break_frame", 32'(n_cap[1]), 32'h03C);

    // ---------------- 5O2 loopback 0x13 ----------------
    frame = {7'b0, 1'b1, 1'b1, 1'b0, 5'h13, 1'b0};
    for (int b = 0; b < 16; b++) match[b] = 0;
    done_cnt = 0; done_at = -1;
    o_tx_data = 5'h13; o_tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_tx_valid = 1'b0;
    for (int j = 0; j < 144; j++) begin
      if (o_tx === frame[j / 16]) match[j / 16]++;
      if (o_tx_done === 1'b1) begin done_cnt++; done_at = j; end
      @(negedge clk);
    end
    for (int b = 0; b < 9; b++) check($sformatf("o5_bit%0d_clks", b), 32'(match[b]), 32'd16);
    check("o5_done_pulses", 32'(done_cnt), 32'd1);
    check("o5_done_latency", 32'(done_at + 1), 32'd144);
    check("o5_rx_count", 32'(o_vcnt), 32'd1);
    check("o5_rx_frame", 32'(o_cap[0]), 32'h013);

    // ---------------- async reset mid-frame ----------------
    base = n_vcnt;
    n_tx_data = 8'h00; n_tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_tx_low", 32'(n_tx), 32'd0);
    check("pre_rst_rx_data", 32'(n_rx_data), 32'h3C);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(n_tx), 32'd1);
    check("async_rst_tx_ready", 32'(n_tx_ready), 32'd1);
    check("async_rst_rx_valid", 32'(n_rx_valid), 32'd0);
    check("async_rst_rx_data", 32'(n_rx_data), 32'd0);
    check("async_rst_e_rx_data", 32'(e_rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_valid", 32'(n_vcnt), 32'(base));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
